serial_acc_seq: RTL
===================

SERIAL_ACC_SEQ -- requirements
Module: serial_acc_seq

Interface
REQ-001 SHALL have parameter N, default 32, multiplicand width of the upstream bit-serial multiplier.
REQ-002 SHALL have parameter M, default 32, multiplier width of the upstream bit-serial multiplier.
REQ-003 SHALL have parameter G, default 8, accumulator guard bits; legal range G >= 1.
REQ-004 SHALL derive L = N+M (product frame length, bits) and W = N+M+G (accumulator width).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port start, input, 1, frame start request.
REQ-008 SHALL have port clr, input, 1, sampled with start; 1 = frame begins from zero instead of current Y.
REQ-009 SHALL have port aX, input, 1, serial product bit from upstream multiplier, LSB first.
REQ-010 SHALL have port Y, output, W, last completed accumulated sum, unsigned.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when Y updates.
REQ-012 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-013 SHALL have port ovf, output, 1, sticky overflow flag.

Function
REQ-014 SHALL implement two states: IDLE (busy=0) and RUN (busy=1) with a cycle counter cnt in 0..W-1.
REQ-015 SHALL accept start only when in IDLE at a rising edge; the accepting edge ("edge 0") loads internal shift register S with Y (clr=0) or zero (clr=1), clears carry, sets cnt=0, enters RUN.
REQ-016 SHALL ignore start while in RUN; no restart, no effect on count or data.
REQ-017 SHALL sample aX at edges 1..L after edge 0 as product bits 0..L-1; at edges L+1..W it SHALL use 0 for the addend regardless of aX.
REQ-018 SHALL perform one bit-serial full-add per RUN edge: sum = S[0] xor b xor c, c_next = majority(S[0], b, c); S shifts right one place with sum entering S[W-1].
REQ-019 SHALL, after exactly W RUN edges, have S holding (old value + product) mod 2^W in natural bit alignment.
REQ-020 SHALL, at edge W after edge 0, copy S result into Y, pulse done high for the following cycle only, and return to IDLE.
REQ-021 SHALL set ovf at edge W if final carry out is 1; ovf SHALL stay 1 until a frame started with clr=1 or rst.
REQ-022 SHALL clear ovf on a clr=1 frame start, then set it again only by that frame's own carry out.
REQ-023 SHALL hold Y constant during RUN; Y changes only at frame completion or rst.
REQ-024 SHALL allow back-to-back frames: start high in the cycle done is high SHALL be accepted (state already IDLE), giving throughput of one frame per W+1 cycles.
REQ-025 SHALL treat all arithmetic as unsigned, wrapping modulo 2^W.

Reset
REQ-026 SHALL, on rst high at a rising edge, force IDLE, cnt=0, carry=0, S=0, Y=0, done=0, busy=0, ovf=0, overriding any other input including start.
REQ-027 SHALL abandon any in-progress frame on rst with no partial update of Y; aX bits after rst are ignored until a new start.

Verification (defaults N=M=32, G=8, W=72, L=64 unless stated)
REQ-028 Reset: rst high two edges, start=1 throughout -> Y=0, done=0, busy=0, ovf=0; after rst low with start=1, frame begins on the next edge.
REQ-029 Single frame: start,clr=1; stream 0xFFFFFFFE00000001 LSB first on edges 1..64 -> done pulses after edge 72, Y=0x00FFFFFFFE00000001, ovf=0, busy low on done cycle.
REQ-030 Accumulate: second frame clr=0, same stream, start asserted during done cycle -> accepted immediately; Y=0x01FFFFFFFC00000002, ovf=0.
REQ-031 Overflow (G=1, W=65): three frames, first clr=1, each streaming 64 ones -> Y=2^64-3, ovf=1; fourth frame with clr=1 and all-zero stream -> Y=0, ovf=0.
REQ-032 Ignored start/aX: start pulsed at RUN edge 5 and aX=1 on edges 65..72 -> done still exactly after edge 72 of original frame; Y identical to REQ-029.
REQ-033 Reset mid-frame: rst at RUN edge 10 after Y=0x00FFFFFFFE00000001 -> Y=0, busy=0, no done; next frame clr=0 with same stream -> Y=0x00FFFFFFFE00000001.

Source files
------------

// File: rtl/serial_acc_seq.sv
// serial_acc_seq: bit-serial accumulator adding an LSB-first product stream into Y.
// Each frame takes W RUN cycles; Y, done and ovf update together on the last one.
module serial_acc_seq #(
  parameter int N = 32,
  parameter int M = 32,
  parameter int G = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             clr,
  input  logic             aX,
  output logic [N+M+G-1:0] Y,
  output logic             done,
  output logic             busy,
  output logic             ovf
);
  localparam int L = N + M;
  localparam int W = N + M + G;
  localparam int CW = $clog2(W);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] s_q, s_d, y_q, y_d;
  logic c_q, c_d, done_q, done_d, ovf_q, ovf_d;
  logic b, sum, cout, last;
  assign b = (cnt_q < CW'(L)) ? aX : 1'b0;
  assign sum = s_q[0] ^ b ^ c_q;
  assign cout = (s_q[0] & b) | (s_q[0] & c_q) | (b & c_q);
  assign last = cnt_q == CW'(W - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      s_q <= '0;
      c_q <= 1'b0;
      y_q <= '0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      s_q <= s_d;
      c_q <= c_d;
      y_q <= y_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    s_d = s_q;
    c_d = c_q;
    y_d = y_q;
    done_d = 1'b0;
    ovf_d = ovf_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = RUN;
        cnt_d = '0;
        s_d = clr ? '0 : y_q;
        c_d = 1'b0;
        ovf_d = ovf_q & ~clr;
      end
    end else begin
      // Sum bit enters at the top so W shifts leave the result naturally aligned.
      s_d = {sum, s_q[W-1:1]};
      c_d = cout;
      cnt_d = last ? '0 : cnt_q + CW'(1);
      if (last) begin
        state_d = IDLE;
        y_d = {sum, s_q[W-1:1]};
        done_d = 1'b1;
        ovf_d = ovf_q | cout;
      end
    end
  end
  assign Y = y_q;
  assign done = done_q;
  assign busy = state_q == RUN;
  assign ovf = ovf_q;
endmodule
